terrain_check_arbiter: RTL and testbench

- Time-shares the single floor/ramp terrain classifier between up to NREQ movers: tank 1, tank 2, shell 1 and shell 2.
- Runs on the 50 MHz system clock.
- Each frame, every requesting mover gets exactly one terrain lookup, granted round-robin.
- Drives the classifier's X/Y/S inputs, waits out its pipeline latency, then returns the captured floor class and corrected Y to the requester that owns it.

---
 rtl/terrain_check_arbiter.sv | 153 +++++++++++++++
 tb/tb_terrain_check_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/terrain_check_arbiter.sv
// Round-robin time-sharing of the single terrain classifier between movers:
// one lookup per requester per frame, result routed back to its owner.
`timescale 1ns/1ps
module terrain_check_arbiter #(
  parameter int NREQ    = 4,
  parameter int CHK_LAT = 2,
  parameter int IDW     = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_start,
  input  logic [NREQ-1:0]      req,
  input  logic [10*NREQ-1:0]   req_x,
  input  logic [10*NREQ-1:0]   req_y,
  input  logic [10*NREQ-1:0]   req_s,
  output logic [9:0]           chk_x,
  output logic [9:0]           chk_y,
  output logic [9:0]           chk_s,
  input  logic [1:0]           chk_floor,
  input  logic [9:0]           chk_ynew,
  output logic [NREQ-1:0]      gnt,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [1:0]           rsp_class,
  output logic [9:0]           rsp_ynew,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int CW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(CHK_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  state_t              state, state_nxt;
  logic [NREQ-1:0]     served, eligible;
  logic [IDW-1:0]      rr_ptr, win_id, cur_id;
  logic                win_found;
  logic [CW-1:0]       wait_cnt;
  logic                done_flag;
  logic [2*NREQ-1:0]   elig_rot;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    int n;
    n = int'(id) + 1;
    if (n >= NREQ) n = 0;
    return IDW'(n);
  endfunction

  function automatic logic [9:0] pick(input logic [10*NREQ-1:0] vec, input logic [IDW-1:0] id);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++)
      if (IDW'(i) == id) r = vec[10*i +: 10];
    return r;
  endfunction

  assign eligible = req & ~served;

  // Rotate eligibility so bit 0 is the requester at rr_ptr; first set bit wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    elig_rot  = {eligible, eligible} >> rr_ptr;
    for (int off = 0; off < NREQ; off++) begin
      if (!win_found && elig_rot[off]) begin
        win_found = 1'b1;
        idx = int'(rr_ptr) + off;
        if (idx >= NREQ) idx = idx - NREQ;
        win_id = IDW'(idx);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = WAIT;
      WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      served     <= '0;
      rr_ptr     <= '0;
      cur_id     <= '0;
      wait_cnt   <= '0;
      done_flag  <= 1'b0;
      gnt        <= '0;
      busy       <= 1'b0;
      chk_x      <= '0;
      chk_y      <= '0;
      chk_s      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_class  <= '0;
      rsp_ynew   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rsp_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= frame_start & busy;
      if (frame_start) done_flag <= 1'b0;

      case (state)
        IDLE: begin
          if (win_found) begin
            gnt      <= NREQ'(1) << win_id;
            cur_id   <= win_id;
            chk_x    <= pick(req_x, win_id);
            chk_y    <= pick(req_y, win_id);
            chk_s    <= pick(req_s, win_id);
            busy     <= 1'b1;
            wait_cnt <= '0;
            rr_ptr   <= next_id(win_id);
          end else if (!frame_start && !done_flag && (served != '0)) begin
            frame_done <= 1'b1;
            done_flag  <= 1'b1;
          end
        end
        WAIT: wait_cnt <= wait_cnt + CW'(1);
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cur_id;
          rsp_class <= chk_floor;
          rsp_ynew  <= chk_ynew;
          gnt       <= '0;
          busy      <= 1'b0;
        end
        default: ;
      endcase

      // A new frame clears served first; a capture on the same edge still marks its owner.
      if (state == CAPTURE)
        served <= (frame_start ? '0 : served) | (NREQ'(1) << cur_id);
      else if (frame_start)
        served <= '0;
    end
  end

endmodule

// File: tb/tb_terrain_check_arbiter.sv
// Bench for terrain_check_arbiter: transaction-level reference model predicts
// grants and responses; a monitor pops the response scoreboard on rsp_valid.
`timescale 1ns/1ps
module tb_terrain_check_arbiter;
  localparam int NREQ    = 4;
  localparam int CHK_LAT = 2;
  localparam int IDW     = 3;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             frame_start = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [10*NREQ-1:0] req_x = '0, req_y = '0, req_s = '0;
  logic [9:0]       chk_x, chk_y, chk_s;
  logic [1:0]       chk_floor;
  logic [9:0]       chk_ynew;
  logic [NREQ-1:0]  gnt;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [1:0]       rsp_class;
  logic [9:0]       rsp_ynew;
  logic             busy, frame_done, overrun;

  terrain_check_arbiter #(.NREQ(NREQ), .CHK_LAT(CHK_LAT), .IDW(IDW)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .req(req),
    .req_x(req_x), .req_y(req_y), .req_s(req_s),
    .chk_x(chk_x), .chk_y(chk_y), .chk_s(chk_s),
    .chk_floor(chk_floor), .chk_ynew(chk_ynew),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_class(rsp_class), .rsp_ynew(rsp_ynew),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #10 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Classifier stand-in: pure function of X/Y/S behind a two-register pipeline.
  function automatic logic [11:0] classify(input logic [9:0] x, input logic [9:0] y, input logic [9:0] s);
    logic [10:0] sum;
    sum = {1'b0, x} + {1'b0, s};
    if (x == 10'd120) return {2'b01, 10'd10};
    if (sum == 11'd200) return {2'b10, y};
    if (x == 10'd150) return {2'b00, y};
    return {x[1:0] ^ s[1:0], y + s};
  endfunction

  logic [11:0] cls_p1, cls_p2;
  always @(posedge Clk) begin
    cls_p1 <= classify(chk_x, chk_y, chk_s);
    cls_p2 <= cls_p1;
  end
  assign chk_floor = cls_p2[11:10];
  assign chk_ynew  = cls_p2[9:0];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         id;
    logic [1:0] cls;
    logic [9:0] yn;
    int         due;
  } exp_t;

  exp_t        q[$];
  exp_t        rlog[$];
  logic [3:0]  glog[$];

  // Reference model state
  logic [3:0]  served_m;
  int          rr_m, txn_id, txn_due;
  bit          has_txn, done_m, ov_exp, fd_exp;
  logic [9:0]  lat_x, lat_y, lat_s;

  initial forever begin
    @(negedge Clk);
    if (!Reset) begin
      served_m = '0; rr_m = 0; has_txn = 0; txn_id = 0; txn_due = 0;
      done_m = 0; ov_exp = 0; fd_exp = 0;
      lat_x = '0; lat_y = '0; lat_s = '0;
      q.delete();
      check("reset_ctrl", {gnt, busy, rsp_valid, frame_done, overrun}, 40'd0);
      check("reset_rsp_chkx", {rsp_id, rsp_class, rsp_ynew, chk_x}, 40'd0);
      check("reset_chkys", {chk_y, chk_s}, 40'd0);
    end else begin
      bit active, found;
      int k;
      logic [11:0] c;
      active = has_txn && (cyc < txn_due);
      check("gnt", gnt, active ? (4'b1 << txn_id) : 4'b0);
      check("busy", busy, active);
      check("chk_xys", {chk_x, chk_y, chk_s}, {lat_x, lat_y, lat_s});
      check("overrun", overrun, ov_exp);
      check("frame_done", frame_done, fd_exp);

      found = 0; k = 0;
      if (!active)
        for (int off = 0; off < NREQ; off++) begin
          int i;
          i = (rr_m + off) % NREQ;
          if (!found && req[i] && !served_m[i]) begin found = 1; k = i; end
        end
      ov_exp = frame_start && active;
      fd_exp = !active && !found && (served_m != 0) && !done_m && !frame_start;
      if (fd_exp) done_m = 1;
      if (found) begin
        lat_x = req_x[10*k +: 10];
        lat_y = req_y[10*k +: 10];
        lat_s = req_s[10*k +: 10];
        c = classify(lat_x, lat_y, lat_s);
        has_txn = 1; txn_id = k;
        txn_due = cyc + 1 + CHK_LAT + 1;
        rr_m = (k + 1) % NREQ;
        served_m[k] = 1'b1;
        q.push_back('{id: k, cls: c[11:10], yn: c[9:0], due: txn_due});
      end
      if (frame_start) begin
        done_m = 0;
        served_m = (active || found) ? 4'(1 << txn_id) : 4'b0;
      end
    end
  end

  logic [3:0] prev_g = '0;
  initial forever begin
    exp_t e;
    @(posedge Clk); #1;
    if (Reset) begin
      if (gnt != 0 && prev_g == 0) glog.push_back(gnt);
      prev_g = gnt;
      if (rsp_valid) begin
        rlog.push_back('{id: int'(rsp_id), cls: rsp_class, yn: rsp_ynew, due: cyc});
        check("rsp_expected", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_class", rsp_class, e.cls);
          check("rsp_ynew", rsp_ynew, e.yn);
          check("rsp_latency", cyc, e.due);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        check("rsp_valid_due", rsp_valid, 1'b1);
        e = q.pop_front();
      end
    end else begin
      prev_g = '0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_gnt(input logic [3:0] exp, input bit any);
    logic [3:0] g;
    for (int i = 0; i < 40 && glog.size() == 0; i++) step(1);
    check("gnt_seen", glog.size() > 0, 1'b1);
    if (glog.size() > 0) begin
      g = glog.pop_front();
      if (any) check("gnt_onehot", $onehot(g), 1'b1);
      else     check("gnt_order", g, exp);
    end
  endtask

  task automatic set_fields(input int i, input logic [9:0] x, input logic [9:0] y, input logic [9:0] s);
    req_x[10*i +: 10] = x;
    req_y[10*i +: 10] = y;
    req_s[10*i +: 10] = s;
  endtask

  task automatic rand_fields(input int i);
    logic [9:0] x, y, s;
    x = 10'($urandom_range(0, 1023));
    y = 10'($urandom_range(0, 1023));
    s = 10'($urandom_range(0, 255));
    case ($urandom_range(0, 4))
      0: x = 10'd120;
      1: x = 10'd150;
      2: begin x = 10'($urandom_range(0, 200)); s = 10'd200 - x; end
      default: ;
    endcase
    set_fields(i, x, y, s);
  endtask

  initial begin
    int n;
    step(3);
    Reset = 1'b1;
    step(2);

    // Idle frame: nothing requested, nothing happens
    req = 4'b0000;
    pulse_fs();
    step(10);

    // Full frame from rr_ptr=0
    set_fields(0, 10'd10,  10'd20,  10'd5);
    set_fields(1, 10'd120, 10'd300, 10'd8);
    set_fields(2, 10'd180, 10'd77,  10'd20);
    set_fields(3, 10'd150, 10'd40,  10'd3);
    glog.delete(); rlog.delete();
    req = 4'b1111;
    pulse_fs();
    wait_gnt(4'b0001, 0);
    wait_gnt(4'b0010, 0);
    wait_gnt(4'b0100, 0);
    wait_gnt(4'b1000, 0);
    step(8);
    check("frame1_rsp_count", rlog.size(), 4);
    if (rlog.size() == 4) begin
      check("r1_id_class_ynew", {rlog[1].id[2:0], rlog[1].cls, rlog[1].yn}, {3'd1, 2'b01, 10'd10});
      check("r2_id_class_ynew", {rlog[2].id[2:0], rlog[2].cls, rlog[2].yn}, {3'd2, 2'b10, 10'd77});
      check("r3_id_class_ynew", {rlog[3].id[2:0], rlog[3].cls, rlog[3].yn}, {3'd3, 2'b00, 10'd40});
      check("r0_class_11", rlog[0].cls, 2'b11);
    end

    // Frame ending on requester 2, then wrap starting at requester 3
    glog.delete();
    req = 4'b0111;
    pulse_fs();
    wait_gnt(4'b0001, 0);
    wait_gnt(4'b0010, 0);
    wait_gnt(4'b0100, 0);
    step(8);
    glog.delete();
    req = 4'b1111;
    pulse_fs();
    wait_gnt(4'b1000, 0);
    wait_gnt(4'b0001, 0);
    wait_gnt(4'b0010, 0);
    wait_gnt(4'b0100, 0);
    step(8);

    // frame_start during requester 0's wait
    glog.delete();
    req = 4'b0001;
    pulse_fs();
    wait_gnt(4'b0001, 0);
    req = 4'b1111;
    pulse_fs();
    check("overrun_pulse", overrun, 1'b1);
    wait_gnt(4'b0010, 0);
    wait_gnt(4'b0100, 0);
    wait_gnt(4'b1000, 0);
    step(10);
    check("req0_not_reserved", glog.size(), 0);

    // Randomized frames with mid-frame request drops and field churn
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < NREQ; i++) rand_fields(i);
      req = 4'($urandom_range(0, 15));
      pulse_fs();
      n = $urandom_range(2, 24);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 9) == 0) req = req & 4'($urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) rand_fields($urandom_range(0, 3));
        step(1);
      end
    end
    step(20);

    // Reset during WAIT aborts the lookup; a fresh grant follows
    glog.delete();
    req = 4'b1111;
    pulse_fs();
    wait_gnt(4'b0000, 1);
    step(1);
    Reset = 1'b0;
    #1;
    check("async_reset_gnt", gnt, 4'b0000);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_rsp", rsp_valid, 1'b0);
    step(2);
    Reset = 1'b1;
    glog.delete();
    req = 4'b0001;
    pulse_fs();
    wait_gnt(4'b0001, 0);
    step(12);
    check("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
